// File: rtl/g25_hex_pkg.sv
// Shared types and constants for the hex scroller display stage.
package g25_hex_pkg;

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_SCROLL = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/g25_hex7seg.sv
// Combinational nibble to active-low seven-segment decoder with blanking.
module g25_hex7seg
    import g25_hex_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            seg_c = SEG_TABLE[nibble];
        end
    end

endmodule

// File: rtl/g25_hex_scroller.sv
// Scrolls a 32-bit PIO word plus blank gap across four seven-segment digits,
// reloading from position 0 whenever the word changes.
module g25_hex_scroller
    import g25_hex_pkg::*;
#(
    parameter int unsigned STEP_CYCLES  = 25_000_000,
    parameter int unsigned BLANK_DIGITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] word_in,
    input  logic        enable,
    input  logic        freeze,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic [3:0]  pos
);

    localparam int unsigned SYM_LEN = 8 + BLANK_DIGITS;
    localparam int unsigned PRESC_W = $clog2(STEP_CYCLES);

    state_e               state_q, state_d;
    logic [31:0]          word_q, word_d;
    logic [3:0]           pos_q, pos_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [3:0][6:0]      hex_q, hex_d;

    logic [4:0]           idx_c   [4];
    logic [3:0]           nib_c   [4];
    logic                 blank_c [4];
    logic [6:0]           seg_c   [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BLANK;
            word_q  <= '0;
            pos_q   <= '0;
            presc_q <= '0;
            hex_q   <= {4{SEG_BLANK}};
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pos_q   <= pos_d;
            presc_q <= presc_d;
            hex_q   <= hex_d;
        end
    end

    // Mode FSM, prescaler and position; enable-low then a new word override last.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pos_d   = pos_q;
        presc_d = presc_q;
        case (state_q)
            S_BLANK: begin
                pos_d   = '0;
                presc_d = '0;
                if (enable) begin
                    state_d = freeze ? S_HOLD : S_SCROLL;
                end
            end
            S_SCROLL: begin
                if (freeze) begin
                    state_d = S_HOLD;
                end else if (presc_q == PRESC_W'(STEP_CYCLES - 1)) begin
                    presc_d = '0;
                    pos_d   = (pos_q == 4'(SYM_LEN - 1)) ? 4'd0 : pos_q + 4'd1;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            S_HOLD: begin
                if (!freeze) begin
                    state_d = S_SCROLL;
                end
            end
            default: state_d = S_BLANK;
        endcase
        if (!enable) begin
            state_d = S_BLANK;
            pos_d   = '0;
            presc_d = '0;
        end
        if (word_in != word_q) begin
            word_d  = word_in;
            pos_d   = '0;
            presc_d = '0;
        end
    end

    // Window mux: digit d (3 = leftmost) shows symbol (pos + 3 - d) mod L.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            idx_c[d] = 5'(pos_q) + 5'(3 - d);
            if (idx_c[d] >= 5'(SYM_LEN)) begin
                idx_c[d] = idx_c[d] - 5'(SYM_LEN);
            end
            nib_c[d]   = word_q[{3'd7 - idx_c[d][2:0], 2'b00} +: 4];
            blank_c[d] = (state_q == S_BLANK) || (idx_c[d] >= 5'd8);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dec
        g25_hex7seg u_dec (
            .nibble (nib_c[g]),
            .blank  (blank_c[g]),
            .seg_c  (seg_c[g])
        );
        assign hex_d[g] = seg_c[g];
    end

    assign hex3 = hex_q[3];
    assign hex2 = hex_q[2];
    assign hex1 = hex_q[1];
    assign hex0 = hex_q[0];
    assign pos  = pos_q;

endmodule
